display_scan_scheduler: RTL and testbench

//  Time-multiplexes the 4-digit 7-segment display between the CT count and the F count.

---
 rtl/display_scan_scheduler_pkg.sv | 31 +++
 rtl/display_scan_scheduler_scan_prescaler.sv | 35 +++
 rtl/display_scan_scheduler.sv | 149 ++++++++++++++
 tb/tb_display_scan_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_scheduler_pkg.sv
// Package display_pkg
//   Shared types and constants for the scanned 7-segment display path.
//   - scan_state_t : display source state (blank / CT count / F count)
//   - GLY_*        : glyph codes understood by the downstream segment decoder
//                    (digit glyphs 0..9 use their own value as the code)
//   - NUM_DIGITS   : number of multiplexed digits, IDX_W bits to index them
//   - ones_glyph() : glyph code for the units digit of a 0..15 value
package display_pkg;

  typedef enum logic [1:0] {
    S_BLANK   = 2'd0,
    S_SHOW_CT = 2'd1,
    S_SHOW_F  = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [3:0] GLY_0     = 4'h0;
  localparam logic [3:0] GLY_1     = 4'h1;
  localparam logic [3:0] GLY_C     = 4'hC;
  localparam logic [3:0] GLY_F     = 4'hE;
  localparam logic [3:0] GLY_BLANK = 4'hF;

  // Units digit of a 4-bit binary value; the tens digit can only be 0 or 1,
  // so a single conditional subtract is enough.
  function automatic logic [3:0] ones_glyph(input logic [3:0] v);
    return GLY_0 + ((v >= 4'd10) ? (v - 4'd10) : v);
  endfunction

endpackage

// File: rtl/display_scan_scheduler_scan_prescaler.sv
// Module scan_prescaler
//   Divides the system clock into digit scan slots. The counter runs
//   0..PRESCALE-1 and slot_tick is high during the cycle in which it sits at
//   PRESCALE-1, after which it wraps to 0. PRESCALE=1 ticks every cycle.
// Ports
//   clk        in  system clock, rising edge
//   rst        in  asynchronous reset, active-low
//   slot_tick  out one-cycle pulse marking the end of a scan slot
module scan_prescaler #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] PRESCALE = WIDTH'(1)
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick
);

  localparam logic [WIDTH-1:0] LAST = PRESCALE - WIDTH'(1);

  logic [WIDTH-1:0] count_q;

  assign slot_tick = (count_q == LAST);

  // Free-running slot counter, wraps on the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (slot_tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Module display_scan_scheduler
//   Time-multiplexes the 4-digit display between the CT count and the F count.
//   The source is picked manually (funct_select) or alternated every DWELL
//   frames (auto_en). The source and the displayed value only change at a
//   frame boundary, so one frame never mixes two samples.
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-low
//   funct_select  in   manual source: 0 = CT, 1 = F
//   auto_en       in   1 = alternate CT/F every DWELL frames (wins over funct_select)
//   blank         in   1 = all digits off, scanning keeps running
//   count_ct      in   CT count 0..15
//   count_f       in   F count 0..15
//   digit_en      out  digit anodes, active-low
//   glyph         out  glyph code for the enabled digit
//   src_is_f      out  source currently displayed (0 = CT, 1 = F)
//   frame_tick    out  one-cycle pulse after the digit index wraps 3->0
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd50000,
  parameter logic [7:0]  DWELL    = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       funct_select,
  input  logic       auto_en,
  input  logic       blank,
  input  logic [3:0] count_ct,
  input  logic [3:0] count_f,
  output logic [3:0] digit_en,
  output logic [3:0] glyph,
  output logic       src_is_f,
  output logic       frame_tick
);

  localparam logic [7:0]       DWELL_LAST = DWELL - 8'd1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  logic             slot_tick;
  logic             boundary;
  logic             auto_rise;
  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       dwell_q, dwell_d, dwell_eff;
  logic [3:0]       snap_q, snap_d;
  logic             auto_q;
  logic             show;
  logic [3:0]       glyph_raw, glyph_d, digit_en_d;

  scan_prescaler #(
    .WIDTH    (16),
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick)
  );

  // Digit index advances once per scan slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else if (slot_tick) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A frame boundary is the slot tick that wraps the index back to digit 0.
  // A rising auto_en restarts the dwell count; if it rises on a boundary the
  // cleared value is what that boundary's auto decision sees.
  always_comb begin
    boundary  = slot_tick && (idx_q == LAST_IDX);
    auto_rise = auto_en && !auto_q;
    dwell_eff = auto_rise ? 8'd0 : dwell_q;
    state_d   = state_q;
    dwell_d   = dwell_eff;
    snap_d    = snap_q;
    if (boundary) begin
      case (state_q)
        S_BLANK: begin
          state_d = (!auto_en && funct_select) ? S_SHOW_F : S_SHOW_CT;
          dwell_d = 8'd0;
        end
        default: begin
          if (auto_en) begin
            if (dwell_eff == DWELL_LAST) begin
              dwell_d = 8'd0;
              state_d = (state_q == S_SHOW_F) ? S_SHOW_CT : S_SHOW_F;
            end else begin
              dwell_d = dwell_eff + 8'd1;
            end
          end else begin
            state_d = funct_select ? S_SHOW_F : S_SHOW_CT;
            dwell_d = 8'd0;
          end
        end
      endcase
      snap_d = (state_d == S_SHOW_F) ? count_f : count_ct;
    end
  end

  // Source state, dwell count, value snapshot and auto_en history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BLANK;
      dwell_q <= 8'd0;
      snap_q  <= 4'd0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      snap_q  <= snap_d;
      auto_q  <= auto_en;
    end
  end

  // Digit content from the frame snapshot. blank is taken live so it acts
  // on the very next clock rather than waiting for a boundary.
  always_comb begin
    show      = (state_q != S_BLANK) && !blank;
    glyph_raw = GLY_BLANK;
    case (idx_q)
      2'd0:    glyph_raw = ones_glyph(snap_q);
      2'd1:    glyph_raw = (snap_q >= 4'd10) ? GLY_1 : GLY_BLANK;
      2'd2:    glyph_raw = GLY_BLANK;
      default: glyph_raw = (state_q == S_SHOW_F) ? GLY_F : GLY_C;
    endcase
    digit_en_d = show ? ~(4'b0001 << idx_q) : 4'b1111;
    glyph_d    = show ? glyph_raw : GLY_BLANK;
  end

  // Registered outputs. src_is_f follows the next state so it changes on the
  // same edge as the state register, one clock ahead of the digit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_en   <= 4'b1111;
      glyph      <= GLY_BLANK;
      src_is_f   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      digit_en   <= digit_en_d;
      glyph      <= glyph_d;
      src_is_f   <= (state_d == S_SHOW_F);
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Testbench tb_display_scan_scheduler
//   Drives one table row per display frame (with optional mid-frame changes)
//   and compares every cycle of the registered outputs against expected slot
//   records queued when the row is applied. PRESCALE=4 and DWELL=2, so one
//   frame is 16 clocks. Ends with a mid-frame asynchronous reset and a replay
//   of the blank start-up frame.
module tb_display_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs, ae, bl;
  logic [3:0] ct, f;
  logic [3:0] digit_en, glyph;
  logic       src_is_f, frame_tick;

  always #5 clk = ~clk;

  display_scan_scheduler #(
    .PRESCALE (16'd4),
    .DWELL    (8'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .funct_select (fs),
    .auto_en      (ae),
    .blank        (bl),
    .count_ct     (ct),
    .count_f      (f),
    .digit_en     (digit_en),
    .glyph        (glyph),
    .src_is_f     (src_is_f),
    .frame_tick   (frame_tick)
  );

  // One row per frame: values present at the frame's boundary, mid-frame
  // values (fs/ae at digit 1, ct at digit 2), and the expected frame content
  // as glyph nibbles {digit3, digit2, digit1, digit0}.
  typedef struct {
    logic       fs, ae, bl;
    logic [3:0] ct, f;
    logic       fs_mid, ae_mid;
    logic [3:0] ct_mid;
    logic [15:0] glyphs;
    logic       src;
  } vec_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] gl;
  } slot_t;

  vec_t  vec[20];
  slot_t slot_q[$];
  logic  src_q[$];
  logic  exp_src;
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(input logic fs_i, input logic ae_i, input logic bl_i,
                              input logic [3:0] ct_i, input logic [3:0] f_i,
                              input logic fs_m, input logic ae_m, input logic [3:0] ct_m,
                              input logic [15:0] gl_i, input logic src_i);
    vec_t v;
    v.fs = fs_i; v.ae = ae_i; v.bl = bl_i; v.ct = ct_i; v.f = f_i;
    v.fs_mid = fs_m; v.ae_mid = ae_m; v.ct_mid = ct_m;
    v.glyphs = gl_i; v.src = src_i;
    return v;
  endfunction

  task automatic check_field(input string name, input int n,
                             input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, n, actual, expected);
    end
  endtask

  // Queue the four digit slots of one frame.
  task automatic push_frame(input logic blanked, input logic [15:0] glyphs);
    logic [3:0] one;
    slot_t      s;
    one = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      s.en = blanked ? 4'b1111 : ~(one << j);
      s.gl = blanked ? 4'hF : glyphs[4*j +: 4];
      slot_q.push_back(s);
    end
  endtask

  // Called at the negedge after edge n (edges counted from reset release).
  task automatic checkOutput(input int n, input int nrows);
    slot_t s;
    logic  tick_exp;
    if ((n % 16 == 0) && (n / 16 <= nrows) && (src_q.size() > 0))
      exp_src = src_q.pop_front();
    if (slot_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty cycle=%0d actual=none expected=record", n);
    end else begin
      s = slot_q[0];
      check_field("digit_en", n, digit_en, s.en);
      check_field("glyph", n, glyph, s.gl);
      if ((n - 1) % 4 == 3) s = slot_q.pop_front();
    end
    if (n < 16 * (nrows + 1))
      check_field("src_is_f", n, {3'b000, src_is_f}, {3'b000, exp_src});
    tick_exp = (n % 16 == 0);
    check_field("frame_tick", n, {3'b000, frame_tick}, {3'b000, tick_exp});
  endtask

  task automatic applyStimulus(input int n, input int nrows);
    int r;
    if ((n % 16 == 15) && ((n + 1) / 16 <= nrows)) begin
      r  = (n + 1) / 16 - 1;
      fs = vec[r].fs;
      ae = vec[r].ae;
      ct = vec[r].ct;
      f  = vec[r].f;
      push_frame(vec[r].bl, vec[r].glyphs);
      src_q.push_back(vec[r].src);
    end
    r = n / 16 - 1;
    if (r >= 0 && r < nrows) begin
      if (n % 16 == 0) bl = vec[r].bl;
      if (n % 16 == 5) begin
        fs = vec[r].fs_mid;
        ae = vec[r].ae_mid;
      end
      if (n % 16 == 9) ct = vec[r].ct_mid;
    end
  endtask

  // Must be entered at the negedge where reset has just been released.
  task automatic run_table(input int nrows);
    slot_q.delete();
    src_q.delete();
    exp_src = 1'b0;
    push_frame(1'b1, 16'hFFFF);
    for (int n = 1; n <= 16 * (nrows + 1); n++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput(n, nrows);
      applyStimulus(n, nrows);
    end
  endtask

  initial begin
    rst = 1'b1;
    fs = 1'b0; ae = 1'b0; bl = 1'b0; ct = 4'd0; f = 4'd0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_field("reset_digit_en", 0, digit_en, 4'b1111);
    check_field("reset_glyph", 0, glyph, 4'hF);
    check_field("reset_src_is_f", 0, {3'b000, src_is_f}, 4'h0);
    check_field("reset_frame_tick", 0, {3'b000, frame_tick}, 4'h0);

    //            fs  ae  bl  ct     f      fsm aem ctm    glyphs    src
    vec[0]  = mk(0,  0,  0,  4'd13, 4'd7,  0,  0,  4'd13, 16'hCF13, 0);
    vec[1]  = mk(0,  0,  0,  4'd13, 4'd7,  1,  0,  4'd13, 16'hCF13, 0);
    vec[2]  = mk(1,  0,  0,  4'd13, 4'd7,  1,  0,  4'd13, 16'hEFF7, 1);
    vec[3]  = mk(1,  0,  0,  4'd13, 4'd7,  0,  0,  4'd13, 16'hEFF7, 1);
    vec[4]  = mk(1,  0,  0,  4'd13, 4'd5,  1,  0,  4'd13, 16'hEFF5, 1);
    vec[5]  = mk(0,  0,  0,  4'd9,  4'd5,  0,  0,  4'd12, 16'hCFF9, 0);
    vec[6]  = mk(0,  0,  0,  4'd12, 4'd5,  0,  0,  4'd12, 16'hCF12, 0);
    vec[7]  = mk(0,  0,  1,  4'd12, 4'd5,  0,  0,  4'd12, 16'hCF12, 0);
    vec[8]  = mk(0,  0,  0,  4'd3,  4'd5,  0,  0,  4'd3,  16'hCFF3, 0);
    vec[9]  = mk(1,  1,  0,  4'd4,  4'd10, 0,  1,  4'd4,  16'hCFF4, 0);
    vec[10] = mk(0,  1,  0,  4'd4,  4'd10, 1,  1,  4'd4,  16'hEF10, 1);
    vec[11] = mk(1,  1,  0,  4'd4,  4'd10, 1,  1,  4'd4,  16'hEF10, 1);
    vec[12] = mk(0,  1,  0,  4'd4,  4'd10, 0,  1,  4'd4,  16'hCFF4, 0);
    vec[13] = mk(0,  1,  0,  4'd15, 4'd10, 0,  0,  4'd15, 16'hCF15, 0);
    vec[14] = mk(0,  1,  0,  4'd15, 4'd0,  0,  1,  4'd15, 16'hCF15, 0);
    vec[15] = mk(1,  1,  0,  4'd15, 4'd0,  1,  1,  4'd15, 16'hEFF0, 1);
    vec[16] = mk(0,  1,  0,  4'd15, 4'd3,  0,  1,  4'd15, 16'hEFF3, 1);
    vec[17] = mk(1,  0,  0,  4'd15, 4'd3,  1,  0,  4'd15, 16'hEFF3, 1);
    vec[18] = mk(0,  1,  0,  4'd15, 4'd8,  0,  1,  4'd15, 16'hEFF8, 1);
    vec[19] = mk(0,  1,  0,  4'd0,  4'd8,  0,  1,  4'd0,  16'hCFF0, 0);

    rst = 1'b1;
    run_table(20);

    // Frame 21 keeps showing CT 0; pull reset while digit 2 is lit.
    repeat (9) @(posedge clk);
    #2;
    check_field("pre_reset_digit_en", 345, digit_en, 4'b1011);
    rst = 1'b0;
    #1;
    check_field("async_digit_en", 345, digit_en, 4'b1111);
    check_field("async_glyph", 345, glyph, 4'hF);
    check_field("async_src_is_f", 345, {3'b000, src_is_f}, 4'h0);
    check_field("async_frame_tick", 345, {3'b000, frame_tick}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    bl = 1'b0;
    rst = 1'b1;
    vec[0] = mk(0, 0, 0, 4'd6, 4'd1, 0, 0, 4'd6, 16'hCFF6, 0);
    run_table(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
